// File: rtl/hpdcache_stream_demux_pkg.sv
// Shared types and the selection decoder for the stream demultiplexer.
package hpdcache_stream_demux_pkg;

  typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

  localparam int unsigned SelMaxWidth = 32;

  typedef struct packed {
    logic [7:0] idx;
    logic       legal;
  } sel_dec_t;

  // Decodes a zero-extended selection into a channel index and a legality flag.
  function automatic sel_dec_t sel_decode(input logic [SelMaxWidth-1:0] sel,
                                          input bit one_hot, input int unsigned nout);
    sel_dec_t    res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    if (one_hot) begin
      for (int unsigned i = 0; i < SelMaxWidth; i++) begin
        if (sel[i]) begin
          ones++;
          res.idx = 8'(i);
        end
      end
      res.legal = (ones == 1) && (32'(res.idx) < nout);
    end else begin
      res.idx   = sel[7:0];
      res.legal = (sel < nout);
    end
    return res;
  endfunction

endpackage

// File: rtl/hpdcache_demux_fifo.sv
// Registered synchronous FIFO; read data comes straight from the storage registers.
module hpdcache_demux_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/hpdcache_stream_demux.sv
// Valid/ready stream demultiplexer with per-channel output FIFOs and optional burst lock.
module hpdcache_stream_demux
  import hpdcache_stream_demux_pkg::*;
#(
  parameter int unsigned NOUTPUT     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          ONE_HOT_SEL = 1'b0,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter bit          BURST_LOCK  = 1'b1,
  localparam int unsigned SEL_WIDTH  = ONE_HOT_SEL ? NOUTPUT : $clog2(NOUTPUT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATA_WIDTH-1:0]               in_data_i,
  input  logic                                in_last_i,
  input  logic [SEL_WIDTH-1:0]                in_sel_i,
  output logic [NOUTPUT-1:0]                  out_valid_o,
  input  logic [NOUTPUT-1:0]                  out_ready_i,
  output logic [NOUTPUT-1:0][DATA_WIDTH-1:0]  out_data_o,
  output logic [NOUTPUT-1:0]                  out_last_o,
  output logic                                sel_err_o
);

  localparam int unsigned IdxW = $clog2(NOUTPUT);

  logic [SelMaxWidth-1:0]            sel_ext;
  sel_dec_t                          dec;
  lock_state_e                       state_q, state_d;
  logic [IdxW-1:0]                   lock_idx_q, lock_idx_d;
  logic [7:0]                        tgt;
  logic                              legal, tgt_full, accept, sel_err_q;
  logic [NOUTPUT-1:0]                full, empty, push, pop;
  logic [NOUTPUT-1:0][DATA_WIDTH:0]  rdata;

  assign sel_ext = SelMaxWidth'(in_sel_i);

  always_comb begin
    dec      = sel_decode(sel_ext, ONE_HOT_SEL, NOUTPUT);
    legal    = (state_q == StLocked) || dec.legal;
    tgt      = (state_q == StLocked) ? 8'(lock_idx_q) : dec.idx;
    tgt_full = 1'b0;
    for (int unsigned i = 0; i < NOUTPUT; i++) begin
      if (legal && (tgt == 8'(i))) begin
        tgt_full = full[i];
      end
    end
    // Illegal beats are always accepted so they can be dropped.
    in_ready_o = !tgt_full;
    accept     = in_valid_i && in_ready_o;
    for (int unsigned i = 0; i < NOUTPUT; i++) begin
      push[i] = accept && legal && (tgt == 8'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept && dec.legal && !in_last_i) begin
          state_d    = StLocked;
          lock_idx_d = tgt[IdxW-1:0];
        end
      end
      StLocked: begin
        if (accept && in_last_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!BURST_LOCK) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      sel_err_q  <= accept && !legal;
    end
  end

  assign sel_err_o   = sel_err_q;
  assign out_valid_o = ~empty;
  assign pop         = out_valid_o & out_ready_i;

  for (genvar i = 0; i < NOUTPUT; i++) begin : g_fifo
    hpdcache_demux_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push[i]),
      .pop_i  (pop[i]),
      .wdata_i({in_last_i, in_data_i}),
      .rdata_o(rdata[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
    assign out_last_o[i] = rdata[i][DATA_WIDTH];
    assign out_data_o[i] = rdata[i][DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_hpdcache_stream_demux.sv
// Directed bench for the stream demux: default config plus one-hot and 3-channel instances.
module tb_hpdcache_stream_demux;

  logic             clk, rst;
  logic             in_valid, in_last, in_ready, sel_err;
  logic [31:0]      in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_ready, out_valid, out_last;
  logic [3:0][31:0] out_data;

  logic             oh_valid, oh_ready, oh_err;
  logic [3:0]       oh_sel, oh_out_valid, oh_out_last;
  logic [3:0][31:0] oh_out_data;

  logic             t3_valid, t3_ready, t3_err;
  logic [1:0]       t3_sel;
  logic [2:0]       t3_out_valid, t3_out_last;
  logic [2:0][31:0] t3_out_data;

  int checks = 0;
  int errors = 0;

  hpdcache_stream_demux #(
    .NOUTPUT(4), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b0), .FIFO_DEPTH(2), .BURST_LOCK(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .in_sel_i(in_sel),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .sel_err_o(sel_err)
  );

  hpdcache_stream_demux #(
    .NOUTPUT(4), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b1), .FIFO_DEPTH(2), .BURST_LOCK(1'b1)
  ) dut_oh (
    .clk_i(clk), .rst_i(rst), .in_valid_i(oh_valid), .in_ready_o(oh_ready),
    .in_data_i(in_data), .in_last_i(in_last), .in_sel_i(oh_sel),
    .out_valid_o(oh_out_valid), .out_ready_i(out_ready), .out_data_o(oh_out_data),
    .out_last_o(oh_out_last), .sel_err_o(oh_err)
  );

  hpdcache_stream_demux #(
    .NOUTPUT(3), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b0), .FIFO_DEPTH(2), .BURST_LOCK(1'b1)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(t3_valid), .in_ready_o(t3_ready),
    .in_data_i(in_data), .in_last_i(in_last), .in_sel_i(t3_sel),
    .out_valid_o(t3_out_valid), .out_ready_i(out_ready[2:0]), .out_data_o(t3_out_data),
    .out_last_o(t3_out_last), .sel_err_o(t3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'hF;
    oh_valid = 1'b0; oh_sel = 4'b0001; t3_valid = 1'b0; t3_sel = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_last", 32'(out_last), 32'h0);
    chk("reset out_data0", out_data[0], 32'h0);
    chk("reset out_data3", out_data[3], 32'h0);
    chk("reset sel_err", 32'(sel_err), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);

    // Basic routing: each beat appears one cycle after acceptance, on its own channel.
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 32'hA0 + 32'(i), 1'b1);
      step();
      chk($sformatf("route valid ch%0d", i), 32'(out_valid), 32'h1 << i);
      chk($sformatf("route data ch%0d", i), out_data[i], 32'hA0 + 32'(i));
      chk($sformatf("route last ch%0d", i), 32'(out_last[i]), 32'h1);
      chk($sformatf("route sel_err ch%0d", i), 32'(sel_err), 32'h0);
    end
    in_valid = 1'b0;
    step();
    chk("route drained", 32'(out_valid), 32'h0);

    // Backpressure on channel 2 does not block channel 1.
    out_ready = 4'b1011;
    send(2'd2, 32'hB0, 1'b1);
    #1 chk("bp ready beat0", 32'(in_ready), 32'h1);
    step();
    send(2'd2, 32'hB1, 1'b1);
    #1 chk("bp ready beat1", 32'(in_ready), 32'h1);
    step();
    send(2'd2, 32'hB2, 1'b1);
    #1 chk("bp ready beat2 full", 32'(in_ready), 32'h0);
    step();
    send(2'd1, 32'hC1, 1'b1);
    #1 chk("bp ready ch1", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp valid", 32'(out_valid), 32'h6);
    chk("bp ch1 data", out_data[1], 32'hC1);
    chk("bp ch2 head", out_data[2], 32'hB0);
    out_ready = 4'hF;
    step();
    chk("bp drain valid", 32'(out_valid), 32'h4);
    chk("bp drain second", out_data[2], 32'hB1);
    step();
    chk("bp drained", 32'(out_valid), 32'h0);

    // Burst lock keeps the whole burst on channel 1 despite changing sel.
    send(2'd1, 32'hD0, 1'b0);
    step();
    chk("lock b0 valid", 32'(out_valid), 32'h2);
    chk("lock b0 data", out_data[1], 32'hD0);
    chk("lock b0 last", 32'(out_last[1]), 32'h0);
    send(2'd3, 32'hD1, 1'b0);
    step();
    chk("lock b1 valid", 32'(out_valid), 32'h2);
    chk("lock b1 data", out_data[1], 32'hD1);
    send(2'd0, 32'hD2, 1'b1);
    step();
    chk("lock b2 valid", 32'(out_valid), 32'h2);
    chk("lock b2 data", out_data[1], 32'hD2);
    chk("lock b2 last", 32'(out_last[1]), 32'h1);
    send(2'd3, 32'hD3, 1'b1);
    step();
    chk("unlock valid", 32'(out_valid), 32'h8);
    chk("unlock data", out_data[3], 32'hD3);
    in_valid = 1'b0;
    step();

    // Illegal selections are accepted, dropped and flagged for one cycle.
    oh_valid = 1'b1; oh_sel = 4'b0110;
    t3_valid = 1'b1; t3_sel = 2'd3;
    in_data = 32'hEE; in_last = 1'b1;
    #1;
    chk("oh illegal ready", 32'(oh_ready), 32'h1);
    chk("t3 illegal ready", 32'(t3_ready), 32'h1);
    step();
    oh_valid = 1'b0; t3_valid = 1'b0;
    chk("oh err pulse", 32'(oh_err), 32'h1);
    chk("t3 err pulse", 32'(t3_err), 32'h1);
    chk("oh no valid", 32'(oh_out_valid), 32'h0);
    chk("t3 no valid", 32'(t3_out_valid), 32'h0);
    step();
    chk("oh err cleared", 32'(oh_err), 32'h0);
    chk("t3 err cleared", 32'(t3_err), 32'h0);
    chk("oh still no valid", 32'(oh_out_valid), 32'h0);
    oh_valid = 1'b1; oh_sel = 4'b0100;
    t3_valid = 1'b1; t3_sel = 2'd2;
    in_data = 32'h5A;
    step();
    oh_valid = 1'b0; t3_valid = 1'b0;
    chk("oh legal valid", 32'(oh_out_valid), 32'h4);
    chk("oh legal data", oh_out_data[2], 32'h5A);
    chk("t3 legal valid", 32'(t3_out_valid), 32'h4);
    chk("oh legal no err", 32'(oh_err), 32'h0);
    step();

    // Full FIFO with a pop in the same cycle: no bypass, nothing lost or duplicated.
    out_ready = 4'b1110;
    send(2'd0, 32'hE0, 1'b1);
    step();
    send(2'd0, 32'hE1, 1'b1);
    step();
    out_ready = 4'hF;
    send(2'd0, 32'hE2, 1'b1);
    #1;
    chk("full ready low", 32'(in_ready), 32'h0);
    chk("full head", out_data[0], 32'hE0);
    step();
    chk("full ready after pop", 32'(in_ready), 32'h1);
    chk("full second", out_data[0], 32'hE1);
    step();
    in_valid = 1'b0;
    chk("full third valid", 32'(out_valid), 32'h1);
    chk("full third", out_data[0], 32'hE2);
    step();
    chk("full drained", 32'(out_valid), 32'h0);

    // Reset while locked with a buffered beat.
    out_ready = 4'b1011;
    send(2'd2, 32'hF0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mid lock valid", 32'(out_valid), 32'h4);
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", 32'(out_valid), 32'h0);
    chk("async rst data2", out_data[2], 32'h0);
    step();
    rst = 1'b0;
    out_ready = 4'hF;
    send(2'd0, 32'h60, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post rst route", 32'(out_valid), 32'h1);
    chk("post rst data", out_data[0], 32'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
